// File: rtl/opti_iir_pkg.sv
// Shared definitions for the biquad cascade: coefficient selects, per-section
// cycle slots, FSM state encoding, and the round/saturate helper.
// Latency: n/a (package).  Backpressure: n/a (package).
package opti_iir_pkg;

    // Coefficient select codes on coef_sel; 5..7 are invalid
    localparam logic [2:0] COEF_B0 = 3'd0;
    localparam logic [2:0] COEF_B1 = 3'd1;
    localparam logic [2:0] COEF_B2 = 3'd2;
    localparam logic [2:0] COEF_A1 = 3'd3;
    localparam logic [2:0] COEF_A2 = 3'd4;

    // Cycle slots within one section; C_W0 is the feedback round/saturate slot
    localparam logic [2:0] C_A1 = 3'd0;
    localparam logic [2:0] C_A2 = 3'd1;
    localparam logic [2:0] C_W0 = 3'd2;
    localparam logic [2:0] C_B0 = 3'd3;
    localparam logic [2:0] C_B1 = 3'd4;
    localparam logic [2:0] C_B2 = 3'd5;
    localparam int         SEC_CYC = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic        clamped;
        logic [31:0] val;
    } rs_t;

    // Round half-up at bit frac, then clamp to a signed dw-bit range.
    // Works for accumulators up to 64 bits and sample widths up to 32 bits.
    function automatic rs_t rnd_sat(input logic signed [63:0] acc,
                                    input int frac, input int dw);
        logic signed [63:0] r, hi, lo;
        rs_t res;
        r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        res.clamped = (r > hi) || (r < lo);
        if (r > hi)      r = hi;
        else if (r < lo) r = lo;
        res.val = r[31:0];
        return res;
    endfunction

endpackage

// File: rtl/opti_mac.sv
// Signed multiply-accumulate shared by every section of the cascade.
// Latency: product folds into the registered accumulator in 1 cycle; acc_d_o is the same-cycle next value.
// Backpressure: none; driven every cycle, en_i=0 holds the accumulator.
// Ports: a_i/b_i multiplicands, init_i load value used with clr_i,
//        sub_i subtracts the product, acc_q_o registered sum, acc_d_o next sum.
module opti_mac #(
    parameter int A_W   = 24,
    parameter int B_W   = 24,
    parameter int ACC_W = 51
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic                    clr_i,
    input  logic                    sub_i,
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    input  logic signed [ACC_W-1:0] init_i,
    output logic signed [ACC_W-1:0] acc_d_o,
    output logic signed [ACC_W-1:0] acc_q_o
);
    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] base;

    assign prod     = a_i * b_i;
    assign prod_ext = $signed({{(ACC_W-P_W){prod[P_W-1]}}, prod});
    // clr_i starts a new sum from init_i instead of the running accumulator
    assign base     = clr_i ? init_i : acc_q_o;

    always_comb begin
        acc_d_o = acc_q_o;
        if (en_i) acc_d_o = sub_i ? (base - prod_ext) : (base + prod_ext);
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q_o <= '0;
        else     acc_q_o <= acc_d_o;
    end

endmodule

// File: rtl/opti_sos_cascade.sv
// Cascade of N_SOS DF-II biquads on one time-multiplexed MAC, 6 cycles per section.
// Latency: data_valid_out 6*N_SOS+1 cycles after accept; one sample per 6*N_SOS+2 cycles.
// Backpressure: data_ready_out high only in IDLE; input held off through RUN and DONE.
// Ports: data_in/data_valid_in/data_ready_out sample input; data_out/data_valid_out result;
//        coef_* runtime coefficient writes (coef_err on reject); bypass per section;
//        state_clr/sat_clr/sat_sticky housekeeping; trace_sec/trace_w1/trace_w2 state view.
module opti_sos_cascade
    import opti_iir_pkg::*;
#(
    parameter int N_SOS     = 4,
    parameter int DATA_W    = 24,
    parameter int COEF_W    = 24,
    parameter int COEF_FRAC = 22,
    parameter int SEC_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     data_valid_in,
    output logic                     data_ready_out,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     data_valid_out,
    input  logic                     coef_we,
    input  logic [SEC_W-1:0]         coef_sec,
    input  logic [2:0]               coef_sel,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     coef_err,
    input  logic [N_SOS-1:0]         bypass,
    input  logic                     state_clr,
    input  logic                     sat_clr,
    output logic                     sat_sticky,
    input  logic [SEC_W-1:0]         trace_sec,
    output logic signed [DATA_W-1:0] trace_w1,
    output logic signed [DATA_W-1:0] trace_w2
);
    localparam int ACC_W = DATA_W + COEF_W + 3;
    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1) << COEF_FRAC;

    state_e                   state_q, state_d;
    logic [SEC_W-1:0]         sec_q;
    logic [2:0]               slot_q;
    logic signed [DATA_W-1:0] x_q, w0_q;
    logic [N_SOS-1:0]         byp_q;
    logic                     clr_pend_q;
    logic signed [DATA_W-1:0] w1_q [N_SOS];
    logic signed [DATA_W-1:0] w2_q [N_SOS];
    logic signed [COEF_W-1:0] coef_q [N_SOS][5];

    logic accept, coef_ok, last_slot, last_sec, sat_set, cur_byp;
    logic signed [DATA_W-1:0] cur_w1, cur_w2, w0_sat, y_sat, trace_w1_d, trace_w2_d;
    logic signed [COEF_W-1:0] cur_b0, cur_b1, cur_b2, cur_a1, cur_a2;
    logic                     mac_en, mac_clr, mac_sub;
    logic signed [DATA_W-1:0] mac_a;
    logic signed [COEF_W-1:0] mac_b;
    logic signed [ACC_W-1:0]  mac_init, mac_acc_d, mac_acc_q, x_ext;
    rs_t                      w0_rs, y_rs;

    assign data_ready_out = (state_q == ST_IDLE);
    assign accept    = data_valid_in && data_ready_out;
    assign coef_ok   = coef_we && (state_q == ST_IDLE) && !accept
                       && (32'(coef_sec) < N_SOS) && (coef_sel <= COEF_A2);
    assign last_slot = (state_q == ST_RUN) && (slot_q == 3'(SEC_CYC - 1));
    assign last_sec  = (sec_q == SEC_W'(N_SOS - 1));
    assign x_ext     = $signed({{(ACC_W-DATA_W){x_q[DATA_W-1]}}, x_q}) <<< COEF_FRAC;

    // Feedback node rounds the registered a-side sum; output rounds the
    // same-cycle total so the b2 product needs no extra cycle.
    assign w0_rs  = rnd_sat({{(64-ACC_W){mac_acc_q[ACC_W-1]}}, mac_acc_q}, COEF_FRAC, DATA_W);
    assign y_rs   = rnd_sat({{(64-ACC_W){mac_acc_d[ACC_W-1]}}, mac_acc_d}, COEF_FRAC, DATA_W);
    assign w0_sat = DATA_W'(w0_rs.val);
    assign y_sat  = DATA_W'(y_rs.val);
    assign sat_set = (state_q == ST_RUN) && !cur_byp
                     && (((slot_q == C_W0) && w0_rs.clamped) || (last_slot && y_rs.clamped));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (data_valid_in) state_d = ST_RUN;
            ST_RUN:  if (last_slot && last_sec) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Current-section operand and trace selection
    always_comb begin
        cur_w1 = '0; cur_w2 = '0; cur_byp = 1'b0;
        cur_b0 = '0; cur_b1 = '0; cur_b2 = '0; cur_a1 = '0; cur_a2 = '0;
        trace_w1_d = '0; trace_w2_d = '0;
        for (int s = 0; s < N_SOS; s++) begin
            if (sec_q == SEC_W'(s)) begin
                cur_w1 = w1_q[s];            cur_w2 = w2_q[s];
                cur_byp = byp_q[s];
                cur_b0 = coef_q[s][COEF_B0]; cur_b1 = coef_q[s][COEF_B1];
                cur_b2 = coef_q[s][COEF_B2]; cur_a1 = coef_q[s][COEF_A1];
                cur_a2 = coef_q[s][COEF_A2];
            end
            if (trace_sec == SEC_W'(s)) begin
                trace_w1_d = w1_q[s];
                trace_w2_d = w2_q[s];
            end
        end
    end

    always_comb begin
        mac_en = 1'b0; mac_clr = 1'b0; mac_sub = 1'b0;
        mac_a = cur_w1; mac_b = cur_a1; mac_init = '0;
        if (state_q == ST_RUN) begin
            case (slot_q)
                C_A1: begin mac_en = 1'b1; mac_clr = 1'b1; mac_sub = 1'b1; mac_init = x_ext; end
                C_A2: begin mac_en = 1'b1; mac_sub = 1'b1; mac_a = cur_w2; mac_b = cur_a2; end
                C_B0: begin mac_en = 1'b1; mac_clr = 1'b1; mac_a = w0_q; mac_b = cur_b0; end
                C_B1: begin mac_en = 1'b1; mac_b = cur_b1; end
                C_B2: begin mac_en = 1'b1; mac_a = cur_w2; mac_b = cur_b2; end
                default: ;
            endcase
        end
    end

    opti_mac #(.A_W(DATA_W), .B_W(COEF_W), .ACC_W(ACC_W)) u_mac (
        .clk(clk), .rst(rst), .en_i(mac_en), .clr_i(mac_clr), .sub_i(mac_sub),
        .a_i(mac_a), .b_i(mac_b), .init_i(mac_init),
        .acc_d_o(mac_acc_d), .acc_q_o(mac_acc_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE; sec_q <= '0; slot_q <= '0;
            x_q <= '0; w0_q <= '0; byp_q <= '0; clr_pend_q <= 1'b0;
            data_out <= '0; data_valid_out <= 1'b0; coef_err <= 1'b0;
            sat_sticky <= 1'b0; trace_w1 <= '0; trace_w2 <= '0;
            for (int s = 0; s < N_SOS; s++) begin
                w1_q[s] <= '0; w2_q[s] <= '0;
                coef_q[s][COEF_B0] <= COEF_ONE; coef_q[s][COEF_B1] <= '0;
                coef_q[s][COEF_B2] <= '0;       coef_q[s][COEF_A1] <= '0;
                coef_q[s][COEF_A2] <= '0;
            end
        end else begin
            state_q        <= state_d;
            data_valid_out <= 1'b0;
            coef_err       <= coef_we && !coef_ok;
            trace_w1       <= trace_w1_d;
            trace_w2       <= trace_w2_d;
            // a fresh clamp beats a simultaneous clear
            if (sat_set)      sat_sticky <= 1'b1;
            else if (sat_clr) sat_sticky <= 1'b0;

            for (int s = 0; s < N_SOS; s++)
                if (coef_ok && coef_sec == SEC_W'(s)) coef_q[s][coef_sel] <= coef_data;

            case (state_q)
                ST_IDLE: begin
                    if (state_clr)
                        for (int s = 0; s < N_SOS; s++) begin w1_q[s] <= '0; w2_q[s] <= '0; end
                    if (accept) begin
                        x_q <= data_in; byp_q <= bypass; sec_q <= '0; slot_q <= '0;
                    end
                end
                ST_RUN: begin
                    // clearing mid-sample would corrupt it; defer to the return to IDLE
                    if (state_clr) clr_pend_q <= 1'b1;
                    if (slot_q == C_W0) w0_q <= w0_sat;
                    if (last_slot) begin
                        slot_q <= '0;
                        sec_q  <= sec_q + 1'b1;
                        if (!cur_byp) begin
                            x_q <= y_sat;
                            for (int s = 0; s < N_SOS; s++)
                                if (sec_q == SEC_W'(s)) begin
                                    w2_q[s] <= w1_q[s];
                                    w1_q[s] <= w0_q;
                                end
                        end
                    end else begin
                        slot_q <= slot_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    data_out       <= x_q;
                    data_valid_out <= 1'b1;
                    clr_pend_q     <= 1'b0;
                    if (clr_pend_q || state_clr)
                        for (int s = 0; s < N_SOS; s++) begin w1_q[s] <= '0; w2_q[s] <= '0; end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_opti_sos_cascade.sv
// Scoreboard bench for opti_sos_cascade: the driver queues hand-computed results
// and accept cycles; a negedge monitor pops them on every data_valid_out.
// Ends with a single TB_RESULT summary line.
module tb_opti_sos_cascade;
    import opti_iir_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, data_valid_in, data_ready_out, data_valid_out;
    logic signed [23:0] data_in, data_out, coef_data, trace_w1, trace_w2;
    logic               coef_we, coef_err, state_clr, sat_clr, sat_sticky;
    logic [3:0]         coef_sec, bypass, trace_sec;
    logic [2:0]         coef_sel;

    opti_sos_cascade dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid_in(data_valid_in),
        .data_ready_out(data_ready_out), .data_out(data_out), .data_valid_out(data_valid_out),
        .coef_we(coef_we), .coef_sec(coef_sec), .coef_sel(coef_sel), .coef_data(coef_data),
        .coef_err(coef_err), .bypass(bypass), .state_clr(state_clr), .sat_clr(sat_clr),
        .sat_sticky(sat_sticky), .trace_sec(trace_sec), .trace_w1(trace_w1), .trace_w2(trace_w2)
    );

    int checks = 0, failures = 0, cyc = 0, last_acc = 0;
    logic signed [23:0] exp_q[$];
    int                 acc_q[$];
    logic signed [23:0] mon_e;
    int                 mon_a;
    int                 burst_acc[10];
    logic signed [23:0] burst_val[10] = '{0, 1, -1, 8388607, -8388608, 123456, -654321, 42, 2000000, -3};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Output monitor: every data_valid_out must match the oldest queued expectation
    always @(negedge clk) begin
        if (data_valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_output: got data_out=%0d with nothing expected", data_out);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = acc_q.pop_front();
                chk("data_out", data_out, mon_e);
                chk("latency", cyc - mon_a, 25);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic send(input logic signed [23:0] d, input logic [3:0] byp,
                        input bit expect_out, input logic signed [23:0] e, input bit hold);
        int n = 0;
        data_in = d; bypass = byp; data_valid_in = 1'b1;
        while (data_ready_out !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("accept_timeout", (n >= 100) ? 1 : 0, 0);
        if (expect_out) begin exp_q.push_back(e); acc_q.push_back(cyc + 1); end
        last_acc = cyc + 1;
        @(negedge clk);
        if (!hold) data_valid_in = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        chk("drain_timeout", (n >= 300) ? 1 : 0, 0);
        @(negedge clk);
    endtask

    task automatic wr_coef(input logic [3:0] s, input logic [2:0] sel,
                           input logic signed [23:0] d, input bit exp_err);
        coef_we = 1'b1; coef_sec = s; coef_sel = sel; coef_data = d;
        @(negedge clk);
        coef_we = 1'b0;
        chk("coef_err", coef_err, exp_err);
        if (exp_err) begin @(negedge clk); chk("coef_err_single_pulse", coef_err, 0); end
    endtask

    task automatic chk_reset_state();
        chk("rst_data_out", data_out, 0);
        chk("rst_valid", data_valid_out, 0);
        chk("rst_ready", data_ready_out, 1);
        chk("rst_coef_err", coef_err, 0);
        chk("rst_sat", sat_sticky, 0);
        chk("rst_trace_w1", trace_w1, 0);
        chk("rst_trace_w2", trace_w2, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; data_in = '0; data_valid_in = 1'b0; coef_we = 1'b0; coef_sec = '0;
        coef_sel = '0; coef_data = '0; bypass = '0; state_clr = 1'b0; sat_clr = 1'b0;
        trace_sec = '0;
        repeat (3) @(negedge clk);
        chk_reset_state();
        rst = 1'b0;
        @(negedge clk);

        // Default coefficients pass the sample through
        send(24'sd1000, 4'b0000, 1, 24'sd1000, 0); drain();
        chk("sat_after_passthrough", sat_sticky, 0);

        // Section 1 gain 0.5, then bypass section 1
        wr_coef(4'd1, COEF_B0, 24'sd2097152, 0);
        send(24'sd1000, 4'b0000, 1, 24'sd500, 0); drain();
        send(24'sd1000, 4'b0010, 1, 24'sd1000, 0); drain();

        // One-pole recursion w0 = x + 0.5*w1 in section 0
        wr_coef(4'd1, COEF_B0, 24'sd4194304, 0);
        wr_coef(4'd0, COEF_A1, -24'sd2097152, 0);
        state_clr = 1'b1; @(negedge clk); state_clr = 1'b0;
        send(24'sd1024, 4'b0000, 1, 24'sd1024, 0); drain();
        chk("trace_w1_1024", trace_w1, 1024);
        send(24'sd0, 4'b0000, 1, 24'sd512, 0); drain();
        chk("trace_w1_512", trace_w1, 512);
        chk("trace_w2_1024", trace_w2, 1024);
        send(24'sd0, 4'b0000, 1, 24'sd256, 0); drain();
        chk("trace_w1_256", trace_w1, 256);
        send(24'sd0, 4'b0000, 1, 24'sd128, 0); drain();
        chk("trace_w1_128", trace_w1, 128);

        // state_clr during RUN: current sample still sees old state, next sees zeros
        send(24'sd0, 4'b0000, 1, 24'sd64, 0);
        repeat (4) @(negedge clk);
        state_clr = 1'b1; @(negedge clk); state_clr = 1'b0;
        drain();
        chk("trace_w1_cleared", trace_w1, 0);
        chk("trace_w2_cleared", trace_w2, 0);
        send(24'sd0, 4'b0000, 1, 24'sd0, 0); drain();

        // Positive saturation and sticky clear
        wr_coef(4'd0, COEF_A1, 24'sd0, 0);
        for (int s = 0; s < 4; s++) wr_coef(4'(s), COEF_B0, 24'sd8346714, 0);
        send(24'sd8388607, 4'b0000, 1, 24'sd8388607, 0); drain();
        chk("sat_set", sat_sticky, 1);
        sat_clr = 1'b1; @(negedge clk); sat_clr = 1'b0;
        chk("sat_cleared", sat_sticky, 0);

        // Rejected coefficient writes
        for (int s = 0; s < 4; s++) wr_coef(4'(s), COEF_B0, 24'sd4194304, 0);
        wr_coef(4'd0, 3'd6, 24'sd123, 1);
        wr_coef(4'd5, COEF_B0, 24'sd123, 1);
        send(-24'sd5000, 4'b0000, 1, -24'sd5000, 0);
        repeat (3) @(negedge clk);
        wr_coef(4'd0, COEF_B0, 24'sd2097152, 1);
        drain();
        send(24'sd7, 4'b0000, 1, 24'sd7, 0); drain();

        // Back-to-back burst with data_valid_in held high
        for (int i = 0; i < 10; i++) begin
            send(burst_val[i], 4'b0000, 1, burst_val[i], (i < 9));
            burst_acc[i] = last_acc;
        end
        data_valid_in = 1'b0;
        drain();
        for (int i = 1; i < 10; i++) chk("burst_spacing", burst_acc[i] - burst_acc[i-1], 26);
        chk("sat_full_scale_no_clamp", sat_sticky, 0);

        // Trace selection, including an out-of-range section
        trace_sec = 4'd7; @(negedge clk); @(negedge clk);
        chk("trace_oob_w1", trace_w1, 0);
        trace_sec = 4'd0; @(negedge clk); @(negedge clk);
        chk("trace_sec0_w1", trace_w1, -3);

        // Reset in the middle of RUN aborts the sample and restores coefficients
        wr_coef(4'd0, COEF_B0, 24'sd2097152, 0);
        send(24'sd999, 4'b0000, 0, 24'sd0, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1; @(negedge clk);
        chk_reset_state();
        rst = 1'b0;
        repeat (40) @(negedge clk);
        send(24'sd1000, 4'b0000, 1, 24'sd1000, 0); drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
